// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the button tick generator.
// Holds the hold/repeat state encoding, the default 100 MHz cycle
// constants and a small helper used to size the repeat counter.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  localparam int DEF_N_BTN        = 3;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;   // 10 ms at 100 MHz
  localparam int DEF_DELAY_CYC    = 50_000_000;  // 500 ms at 100 MHz
  localparam int DEF_RATE_CYC     = 10_000_000;  // 100 ms at 100 MHz

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button's 2-FF synchroniser, debouncer, press-edge
// detector and hold-to-auto-repeat FSM.
// Build option: define BTN_AUTO_REPEAT_EN to enable the HOLD->REPEAT
// auto-repeat ticks; without it a press yields exactly one tick and the
// FSM just waits in HOLD for the release.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int DELAY_CYC    = DEF_DELAY_CYC,
  parameter int RATE_CYC     = DEF_RATE_CYC
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn_raw,
  output logic tick,
  output logic level
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);

  // Reject configurations the counters cannot honour.
  if (DEBOUNCE_CYC < 1 || DELAY_CYC < 2 || RATE_CYC < 2) begin : g_param_check
    $error("btn_channel: DEBOUNCE_CYC>=1, DELAY_CYC>=2 and RATE_CYC>=2 are required");
  end

  logic          s1_q, s2_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          accept;
  logic          rise, fall;
  btn_state_e    state_q, state_d;
  logic          tick_q, tick_d;

  // Two-flop synchroniser; only s2_q is trusted downstream.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, accept on the last one.
  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (s2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      level_d = s2_q;
      dcnt_d  = '0;
      accept  = 1'b1;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  assign rise = accept & s2_q;
  assign fall = accept & ~s2_q;

  // Debounce state registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      dcnt_q  <= '0;
      level_q <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(max_int(DELAY_CYC, RATE_CYC));
  localparam logic [RW-1:0] DELAY_LAST = RW'(DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(RATE_CYC - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;

  // Press/hold/repeat next-state logic; a debounced fall beats any repeat tick.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          tick_d  = 1'b1;
          rcnt_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall) begin
          rcnt_d  = '0;
          state_d = IDLE;
        end else if (rcnt_q == DELAY_LAST) begin
          tick_d  = 1'b1;
          rcnt_d  = '0;
          state_d = REPEAT;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          rcnt_d  = '0;
          state_d = IDLE;
        end else if (rcnt_q == RATE_LAST) begin
          tick_d = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        rcnt_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM registers with the registered tick output.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      tick_q  <= tick_d;
    end
  end
`else
  // Single-tick FSM: tick on the debounced rise, then wait for the fall.
  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          tick_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM registers with the registered tick output.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end
`endif

  assign tick  = tick_q;
  assign level = level_q;

endmodule

// File: rtl/btn_tick_gen.sv
// btn_tick_gen: N_BTN independent button conditioners producing one-cycle
// set pulses and debounced levels for the clock/alarm core.
// Build option: BTN_AUTO_REPEAT_EN enables hold-to-auto-repeat ticks.
module btn_tick_gen
  import btn_pkg::*;
#(
  parameter int N_BTN        = DEF_N_BTN,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int DELAY_CYC    = DEF_DELAY_CYC,
  parameter int RATE_CYC     = DEF_RATE_CYC
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] tick_out,
  output logic [N_BTN-1:0] btn_level
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .DELAY_CYC   (DELAY_CYC),
      .RATE_CYC    (RATE_CYC)
    ) u_chan (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .btn_raw   (btn_in[gi]),
      .tick      (tick_out[gi]),
      .level     (btn_level[gi])
    );
  end

endmodule

// File: tb/tb_btn_tick_gen.sv
// tb_btn_tick_gen: directed and random button stimulus checked cycle by
// cycle against a window-based reference model of debounce and repeat.
module tb_btn_tick_gen;

  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int RTE = 8;

  logic          clk_100MHz = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] tick_out;
  logic [NB-1:0] btn_level;

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] hist[$];
  logic [NB-1:0] exp_level;
  logic [NB-1:0] exp_tick;
  int            press_edge[NB];
  int            tick_count[NB];
  logic [NB-1:0] first_tick_vec;
  bit            seen_tick;

  btn_tick_gen #(
    .N_BTN       (NB),
    .DEBOUNCE_CYC(DEB),
    .DELAY_CYC   (DLY),
    .RATE_CYC    (RTE)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .btn_in    (btn_in),
    .tick_out  (tick_out),
    .btn_level (btn_level)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk_100MHz = ~clk_100MHz;

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Raw level seen by the debouncer before clock edge k (two flops late).
  function automatic logic s2At(input int k, input int ch);
    if (k < 2) return 1'b0;
    return hist[k-2][ch];
  endfunction

  task automatic modelReset();
    hist.delete();
    exp_level = '0;
    exp_tick  = '0;
    for (int ch = 0; ch < NB; ch++) press_edge[ch] = 0;
  endtask

  // A level flips once the last DEB synchronised samples all disagree with it;
  // while held, ticks fall DLY edges after the press and every RTE after that.
  task automatic modelStep(input logic [NB-1:0] sampled);
    int e;
    bit stable;
    hist.push_back(sampled);
    e = hist.size() - 1;
    exp_tick = '0;
    for (int ch = 0; ch < NB; ch++) begin
      stable = 1'b1;
      for (int k = e - DEB + 1; k <= e; k++)
        if (s2At(k, ch) == exp_level[ch]) stable = 1'b0;
      if (stable) begin
        exp_level[ch] = ~exp_level[ch];
        if (exp_level[ch]) begin
          exp_tick[ch]   = 1'b1;
          press_edge[ch] = e;
        end
      end else if (exp_level[ch]) begin
`ifdef BTN_AUTO_REPEAT_EN
        int d;
        d = e - press_edge[ch];
        if (d == DLY || (d > DLY && ((d - DLY) % RTE) == 0)) exp_tick[ch] = 1'b1;
`endif
      end
    end
  endtask

  // One clock: drive, let the edge happen, step the model, compare just after.
  task automatic cycleOnce(input logic [NB-1:0] v);
    btn_in = v;
    @(posedge clk_100MHz);
    modelStep(v);
    #1;
    checkOutput("tick_out", 32'(tick_out), 32'(exp_tick));
    checkOutput("btn_level", 32'(btn_level), 32'(exp_level));
    for (int ch = 0; ch < NB; ch++) if (tick_out[ch]) tick_count[ch]++;
    if (!seen_tick && tick_out != '0) begin
      seen_tick      = 1'b1;
      first_tick_vec = tick_out;
    end
    @(negedge clk_100MHz);
  endtask

  task automatic applyStimulus(input logic [NB-1:0] v, input int n);
    for (int i = 0; i < n; i++) cycleOnce(v);
  endtask

  task automatic clearCounts();
    for (int ch = 0; ch < NB; ch++) tick_count[ch] = 0;
    seen_tick      = 1'b0;
    first_tick_vec = '0;
  endtask

  // Directed scenarios followed by random button traffic.
  initial begin
    int first_idx;
    logic [NB-1:0] rv;
    int rn;

    reset  = 1'b1;
    btn_in = '0;
    modelReset();
    clearCounts();
    repeat (3) @(negedge clk_100MHz);
    checkOutput("reset_tick", 32'(tick_out), 32'd0);
    checkOutput("reset_level", 32'(btn_level), 32'd0);
    reset = 1'b0;

    // Clean press on bit 0.
    clearCounts();
    applyStimulus(3'b001, 10);
    applyStimulus(3'b000, 12);
    checkOutput("clean_ticks0", 32'(tick_count[0]), 32'd1);
    checkOutput("clean_ticks12", 32'(tick_count[1] + tick_count[2]), 32'd0);

    // Bounce on bit 1 never settles long enough.
    clearCounts();
    applyStimulus(3'b010, 3);
    applyStimulus(3'b000, 1);
    applyStimulus(3'b010, 3);
    applyStimulus(3'b000, 10);
    checkOutput("bounce_ticks1", 32'(tick_count[1]), 32'd0);
    applyStimulus(3'b010, 10);
    applyStimulus(3'b000, 12);
    checkOutput("stable_ticks1", 32'(tick_count[1]), 32'd1);

    // Long hold; release timed so the fall lands on a repeat slot (fall wins).
    clearCounts();
    applyStimulus(3'b001, 60);
    applyStimulus(3'b000, 15);
`ifdef BTN_AUTO_REPEAT_EN
    checkOutput("hold_ticks0", 32'(tick_count[0]), 32'd6);
`else
    checkOutput("hold_ticks0", 32'(tick_count[0]), 32'd1);
`endif

    // Simultaneous rise on bits 0 and 2.
    clearCounts();
    applyStimulus(3'b101, 8);
    applyStimulus(3'b000, 12);
    checkOutput("simul_vec", 32'(first_tick_vec), 32'(3'b101));

    // Reset while held in the repeat phase.
    clearCounts();
    applyStimulus(3'b001, 35);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_tick", 32'(tick_out), 32'd0);
    checkOutput("async_level", 32'(btn_level), 32'd0);
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    modelReset();
    first_idx = -1;
    for (int i = 0; i < 10; i++) begin
      cycleOnce(3'b001);
      if (first_idx < 0 && tick_out[0]) first_idx = i;
    end
    // Sixth clock edge after release (edge index DEB+1).
    checkOutput("post_reset_tick_edge", 32'(first_idx), 32'(DEB + 1));
    applyStimulus(3'b000, 12);

    // Random traffic on all channels.
    for (int s = 0; s < 40; s++) begin
      rv = NB'($urandom_range(0, 7));
      rn = $urandom_range(1, 30);
      applyStimulus(rv, rn);
    end
    applyStimulus(3'b000, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
